// File: rtl/tone_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tone_pkg
//  Description : Shared note definitions for the buzzer tone generator and
//                the tone decoder: note indices, full-period table at the
//                reference clock, generator half-periods and decoder states.
//  Revision    : 1.0  initial release
// ============================================================================
package tone_pkg;

  // Reference clock the note tables are expressed against.
  localparam int CK_HZ = 12_000_000;

  typedef enum logic [3:0] {
    C4   = 4'd0,
    D4   = 4'd1,
    E4   = 4'd2,
    F4   = 4'd3,
    G4   = 4'd4,
    A4   = 4'd5,
    B4   = 4'd6,
    C5   = 4'd7,
    NONE = 4'hF
  } note_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    LOCK = 2'd2
  } state_e;

  // Full note periods in reference-clock cycles, C4..C5.
  localparam logic [15:0] NOTE_PERIOD [8] = '{
    16'd45866, 16'd40864, 16'd36404, 16'd34361,
    16'd30612, 16'd27272, 16'd24297, 16'd22934
  };

  // Generator reload values: half a period minus the reload cycle.
  localparam logic [15:0] NOTE_HALF [8] = '{
    16'(NOTE_PERIOD[0] / 16'd2 - 16'd1), 16'(NOTE_PERIOD[1] / 16'd2 - 16'd1),
    16'(NOTE_PERIOD[2] / 16'd2 - 16'd1), 16'(NOTE_PERIOD[3] / 16'd2 - 16'd1),
    16'(NOTE_PERIOD[4] / 16'd2 - 16'd1), 16'(NOTE_PERIOD[5] / 16'd2 - 16'd1),
    16'(NOTE_PERIOD[6] / 16'd2 - 16'd1), 16'(NOTE_PERIOD[7] / 16'd2 - 16'd1)
  };

  // Period of note idx rescaled to a different clock (truncating).
  function automatic logic [15:0] scaled_period(input logic [2:0] idx, input longint ck_hz);
    longint t;
    t = (longint'(NOTE_PERIOD[idx]) * ck_hz) / longint'(CK_HZ);
    return t[15:0];
  endfunction

  // Returns the note whose period lies within tol of p, or NONE.
  function automatic note_e match_note(input logic [15:0] p, input logic [15:0] tol,
                                       input longint ck_hz);
    logic signed [16:0] diff;
    logic signed [16:0] mag;
    logic        [15:0] tref;
    note_e              res;
    res = NONE;
    for (int i = 0; i < 8; i++) begin
      tref = scaled_period(3'(i), ck_hz);
      diff = $signed({1'b0, p}) - $signed({1'b0, tref});
      mag  = (diff < 0) ? -diff : diff;
      if (mag <= $signed({1'b0, tol})) begin
        res = note_e'(4'(i));
      end
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/in_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : in_sync_edge
//  Description : Two-flop synchronizer for an asynchronous input followed by
//                a registered rising-edge strobe (ED high 3 CK after IN rises).
//  Revision    : 1.0  initial release
// ============================================================================
module in_sync_edge (
  input  logic CK,
  input  logic RB,
  input  logic IN,
  output logic ED
);

  logic meta_q;
  logic sync1_q;
  logic sync2_q;
  logic ed_q;
  logic ed_d;

  // Rising edge of the synchronized level.
  always_comb begin
    ed_d = sync1_q & ~sync2_q;
  end

  // Synchronizer chain and strobe register.
  always_ff @(posedge CK) begin
    if (RB) begin
      meta_q  <= 1'b0;
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      ed_q    <= 1'b0;
    end else begin
      meta_q  <= IN;
      sync1_q <= meta_q;
      sync2_q <= sync1_q;
      ed_q    <= ed_d;
    end
  end

  assign ED = ed_q;

endmodule
`default_nettype wire

// File: rtl/tone_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tone_decoder
//  Description : Measures the period of a square-wave tone between rising
//                edges, matches it against the C4..C5 note table and reports
//                a note once MATCH_N consecutive periods agree.
//  Revision    : 1.0  initial release
// ============================================================================
module tone_decoder #(
  parameter int          CK_HZ   = 12_000_000,
  parameter logic [15:0] TOL     = 16'd256,
  parameter int          MATCH_N = 4,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic        CK,
  input  logic        RB,
  input  logic        IN,
  output logic [3:0]  NOTE,
  output logic        VALID,
  output logic [15:0] PERIOD,
  output logic        CHG
);

  import tone_pkg::*;

  logic        ed;

  state_e      state_q,  state_d;
  logic [15:0] cnt_q,    cnt_d;
  logic [15:0] period_q, period_d;
  note_e       cand_q,   cand_d;
  logic [3:0]  mcnt_q,   mcnt_d;
  note_e       note_q,   note_d;
  logic        valid_q,  valid_d;
  logic        chg_q,    chg_d;
  note_e       hit;

  in_sync_edge u_sync (
    .CK (CK),
    .RB (RB),
    .IN (IN),
    .ED (ed)
  );

  // Period measurement, match qualification and lock state machine.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    cand_d   = cand_q;
    mcnt_d   = mcnt_q;
    note_d   = note_q;
    valid_d  = valid_q;
    chg_d    = 1'b0;
    hit      = match_note(cnt_q, TOL, longint'(CK_HZ));

    if (ed) begin
      // A strobe always closes the current period, even on the timeout cycle.
      period_d = cnt_q;
      cnt_d    = 16'd1;
      case (state_q)
        IDLE: begin
          // First edge is only a reference; its count is meaningless.
          state_d = ARM;
          cand_d  = NONE;
          mcnt_d  = 4'd0;
        end
        ARM: begin
          if (hit == NONE) begin
            cand_d = NONE;
            mcnt_d = 4'd0;
          end else if (hit == cand_q) begin
            mcnt_d = mcnt_q + 4'd1;
          end else begin
            cand_d = hit;
            mcnt_d = 4'd1;
          end
          if ((hit != NONE) && (mcnt_d == 4'(MATCH_N))) begin
            state_d = LOCK;
            note_d  = hit;
            valid_d = 1'b1;
            chg_d   = 1'b1;
          end
        end
        LOCK: begin
          if (hit != note_q) begin
            // Drop silently and start qualifying the new period.
            state_d = ARM;
            valid_d = 1'b0;
            note_d  = NONE;
            if (hit == NONE) begin
              cand_d = NONE;
              mcnt_d = 4'd0;
            end else begin
              cand_d = hit;
              mcnt_d = 4'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end else begin
      if (cnt_q != TIMEOUT) begin
        cnt_d = cnt_q + 16'd1;
      end
      if ((state_q != IDLE) && (cnt_q == TIMEOUT)) begin
        state_d = IDLE;
        valid_d = 1'b0;
        note_d  = NONE;
        cand_d  = NONE;
        mcnt_d  = 4'd0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge CK) begin
    if (RB) begin
      state_q  <= IDLE;
      cnt_q    <= 16'd0;
      period_q <= 16'd0;
      cand_q   <= NONE;
      mcnt_q   <= 4'd0;
      note_q   <= NONE;
      valid_q  <= 1'b0;
      chg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      cand_q   <= cand_d;
      mcnt_q   <= mcnt_d;
      note_q   <= note_d;
      valid_q  <= valid_d;
      chg_q    <= chg_d;
    end
  end

  assign NOTE   = note_q;
  assign VALID  = valid_q;
  assign PERIOD = period_q;
  assign CHG    = chg_q;

endmodule
`default_nettype wire

// File: tb/tb_tone_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_tone_decoder
//  Description : Self-checking bench for tone_decoder. The decoder runs at a
//                1/100 clock so the note periods become 458,408,364,343,306,
//                272,242,229 cycles; TOL=5, MATCH_N=4, TIMEOUT=1000.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tone_decoder;

  localparam int H = 50;  // high time of every generated tone pulse

  logic        CK = 1'b0;
  logic        RB = 1'b1;
  logic        IN = 1'b0;
  logic [3:0]  NOTE;
  logic        VALID;
  logic [15:0] PERIOD;
  logic        CHG;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int last_rise = 0;
  int g         = 0;

  typedef struct {
    logic [3:0]  note;
    logic [15:0] per;
    int          at;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  tone_decoder #(
    .CK_HZ   (120_000),
    .TOL     (16'd5),
    .MATCH_N (4),
    .TIMEOUT (16'd1000)
  ) dut (
    .CK     (CK),
    .RB     (RB),
    .IN     (IN),
    .NOTE   (NOTE),
    .VALID  (VALID),
    .PERIOD (PERIOD),
    .CHG    (CHG)
  );

  always #5 CK = ~CK;

  always @(posedge CK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Every CHG pulse must correspond to a scheduled lock event.
  always @(negedge CK) begin
    if (CHG) begin
      chk("chg_expected", 32'(sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        mon_e = sbq.pop_front();
        chk("lock_cycle",  cyc,    mon_e.at);
        chk("lock_note",   NOTE,   mon_e.note);
        chk("lock_valid",  VALID,  1);
        chk("lock_period", PERIOD, mon_e.per);
      end
    end
  end

  // n rising edges spaced per cycles; optional lock push and drop check.
  task automatic tone(input int per, input int n, input int lock_at,
                      input logic [3:0] lnote, input int drop_at);
    for (int k = 1; k <= n; k++) begin
      IN = 1'b0;
      repeat (per - H) @(negedge CK);
      IN = 1'b1;
      last_rise = cyc;
      if (k == lock_at) sbq.push_back('{lnote, 16'(per), cyc + 4});
      for (int j = 0; j < H; j++) begin
        @(negedge CK);
        if ((k == drop_at) && (j == 3)) begin
          chk("drop_valid", VALID, 0);
          chk("drop_note",  NOTE,  4'hF);
        end
      end
    end
  endtask

  task automatic quiet(input int n);
    IN = 1'b0;
    repeat (n) @(negedge CK);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    RB = 1'b1;
    IN = 1'b0;
    repeat (3) @(negedge CK);
    chk("reset_note",   NOTE,   4'hF);
    chk("reset_valid",  VALID,  0);
    chk("reset_period", PERIOD, 0);
    chk("reset_chg",    CHG,    0);
    RB = 1'b0;

    // A4 lock: arming edge plus four matching periods.
    tone(272, 5, 5, 4'd5, 0);
    chk("a4_valid",  VALID,  1);
    chk("a4_note",   NOTE,   4'd5);
    chk("a4_period", PERIOD, 272);
    quiet(1100);
    chk("a4_timeout_valid", VALID, 0);

    // Tolerance boundary: +/-TOL locks, +/-(TOL+1) never does.
    tone(277, 5, 5, 4'd5, 0);
    chk("tol_hi_note", NOTE, 4'd5);
    quiet(1100);
    tone(267, 5, 5, 4'd5, 0);
    chk("tol_lo_note", NOTE, 4'd5);
    quiet(1100);
    tone(278, 6, 0, 4'd0, 0);
    chk("tol_hi_out_valid",  VALID,  0);
    chk("tol_hi_out_note",   NOTE,   4'hF);
    chk("tol_hi_out_period", PERIOD, 278);
    quiet(1100);
    tone(266, 6, 0, 4'd0, 0);
    chk("tol_lo_out_valid",  VALID,  0);
    chk("tol_lo_out_note",   NOTE,   4'hF);
    chk("tol_lo_out_period", PERIOD, 266);
    quiet(1100);

    // Note change A4 -> C5: drop on first C5 edge, relock 3 edges later.
    tone(272, 5, 5, 4'd5, 0);
    tone(229, 4, 4, 4'd7, 1);
    chk("chg_note",  NOTE,  4'd7);
    chk("chg_valid", VALID, 1);
    quiet(1100);

    // Timeout from LOCK on C4, then relock after 1+4 edges.
    tone(458, 5, 5, 4'd0, 0);
    IN = 1'b0;
    g = last_rise;
    while (cyc < g + 1002) @(negedge CK);
    chk("to_before_valid", VALID, 1);
    while (cyc < g + 1005) @(negedge CK);
    chk("to_valid",  VALID,  0);
    chk("to_note",   NOTE,   4'hF);
    chk("to_period", PERIOD, 458);
    tone(458, 5, 5, 4'd0, 0);
    chk("to_relock_note", NOTE, 4'd0);
    quiet(1100);

    // Reset mid-lock on G4, relock on 5th edge after release.
    tone(306, 5, 5, 4'd4, 0);
    IN = 1'b0;
    repeat (50) @(negedge CK);
    RB = 1'b1;
    @(negedge CK);
    RB = 1'b0;
    chk("rst_note",   NOTE,   4'hF);
    chk("rst_valid",  VALID,  0);
    chk("rst_period", PERIOD, 0);
    chk("rst_chg",    CHG,    0);
    repeat (205) @(negedge CK);
    IN = 1'b1;
    repeat (H) @(negedge CK);
    tone(306, 4, 4, 4'd4, 0);
    chk("rst_relock_note", NOTE, 4'd4);
    quiet(1100);

    // Glitch while locked on E4: short period drops lock, then relock.
    tone(364, 5, 5, 4'd2, 0);
    IN = 1'b0;
    repeat (100) @(negedge CK);
    IN = 1'b1;
    g = cyc;
    repeat (2) @(negedge CK);
    IN = 1'b0;
    @(negedge CK);
    chk("gl_pre_valid", VALID, 1);
    @(negedge CK);
    chk("gl_valid",  VALID,  0);
    chk("gl_note",   NOTE,   4'hF);
    chk("gl_period", PERIOD, 150);
    repeat (46) @(negedge CK);
    tone(364, 4, 4, 4'd2, 0);
    chk("gl_relock_valid", VALID, 1);
    chk("gl_relock_note",  NOTE,  4'd2);

    repeat (20) @(negedge CK);
    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
